// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - reset sequencer: sync release, fixed-length hold, software reset
// Optional checker enabled by defining RST_SEQ_MON_EN.
module rst_seq_gen #(
  parameter int HOLD_CYCLES = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  output logic rst_o,
  output logic rst_done,
  output logic sw_ack,
  output logic rst_err
);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   soft_q, soft_d;
  logic                   rst_o_q, rst_o_d;
  logic                   sw_ack_q, sw_ack_d;
  logic                   released;
  logic                   hold_exit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign released  = sync_q[SYNC_STAGES-1];
  assign hold_exit = (state_q == HOLD) && released && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    soft_d   = soft_q;
    rst_o_d  = rst_o_q;
    sw_ack_d = 1'b0;
    case (state_q)
      HOLD: begin
        rst_o_d = 1'b1;
        if (hold_exit) begin
          rst_o_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
          if (soft_q) begin
            sw_ack_d = 1'b1;
            soft_d   = 1'b0;
          end
        end else if (released) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        rst_o_d = 1'b0;
        // sw_req is only honoured here, so a request during HOLD cannot stretch it
        if (sw_req) begin
          rst_o_d = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
          soft_d  = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        rst_o_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      soft_q   <= 1'b0;
      rst_o_q  <= 1'b1;
      sw_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      soft_q   <= soft_d;
      rst_o_q  <= rst_o_d;
      sw_ack_q <= sw_ack_d;
    end
  end

  assign rst_o    = rst_o_q;
  assign rst_done = (state_q == RUN);
  assign sw_ack   = sw_ack_q;

`ifdef RST_SEQ_MON_EN
  logic [CNT_W-1:0] mon_cnt_q;
  logic [CNT_W:0]   mon_len;
  logic             mon_rst_o_prev_q;
  logic             mon_sw_prev_q;
  logic             mon_err_q;

  assign mon_len = {1'b0, mon_cnt_q} + (CNT_W+1)'(1);

  // Window length is counted independently of cnt_q so a corrupted counter is caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_cnt_q        <= '0;
      mon_rst_o_prev_q <= 1'b1;
      mon_sw_prev_q    <= 1'b0;
      mon_err_q        <= 1'b0;
    end else begin
      mon_rst_o_prev_q <= rst_o_q;
      mon_sw_prev_q    <= sw_req;
      if (rst_o_q && !mon_rst_o_prev_q && !mon_sw_prev_q) begin
        mon_err_q <= 1'b1;
      end
      if ((state_q == HOLD) && released) begin
        if (hold_exit) begin
          if (mon_len != (CNT_W+1)'(HOLD_CYCLES)) begin
            mon_err_q <= 1'b1;
          end
          mon_cnt_q <= '0;
        end else begin
          mon_cnt_q <= mon_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign rst_err = mon_err_q;
`else
  assign rst_err = 1'b0;
`endif

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Reset sequencer that drives the block-level reset `rst_o` consumed by downstream logic.
- Asserts `rst_o` asynchronously on `rst`.
- After `rst` release, synchronises the release, holds `rst_o` high for exactly HOLD_CYCLES clock edges, then keeps it low until the next reset or software-reset request.
- Sits directly upstream of every block whose contract is "reset high for N ticks, then low for the rest of the run".

Parameters:
- HOLD_CYCLES, 3, number of posedges at which `rst_o` is sampled high after synchronised release; legal range 1..2^CNT_W-1.
- SYNC_STAGES, 2, depth of the release synchroniser; minimum 2.
- CNT_W, 8, hold-counter width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- sw_req  input  1  software reset request, level sampled on posedge.
- rst_o  output  1  sequenced reset to downstream, active-high.
- rst_done  output  1  high while state==RUN.
- sw_ack  output  1  one-cycle pulse when a software-initiated hold completes.
- rst_err  output  1  sticky monitor error (see Optional Feature).

Behaviour:
- Reset (`rst`=1, asynchronous):
  - sync chain=0, cnt=0, state=HOLD.
  - Outputs: `rst_o`=1, `rst_done`=0, `sw_ack`=0, `rst_err`=0.
  - `rst_o` rises combinationally-free, i.e. directly via the flop async set.
- Release path: after `rst` falls, constant 1 shifts through SYNC_STAGES flops. Let E0 be the first posedge at which the last stage is sampled 1.
- States:
  - HOLD:
    - `rst_o`=1; cnt increments at each posedge with sync released.
    - At the edge where cnt==HOLD_CYCLES-1: `rst_o`<=0, cnt<=0, state<=RUN.
  - RUN:
    - `rst_o`=0, `rst_done`=1.
    - `sw_req`=1 sampled at a posedge: `rst_o`<=1, state<=HOLD, cnt<=0, soft flag<=1.
- Timing contract:
  - `rst_o` is sampled 1 at E0..E0+HOLD_CYCLES-1 inclusive (exactly HOLD_CYCLES posedges).
  - `rst_o` is sampled 0 from E0+HOLD_CYCLES onward, with no glitch or re-assertion unless `rst` or `sw_req` occurs.
- Software hold:
  - Same HOLD_CYCLES count, starting the edge after `rst_o` rises; no synchroniser delay.
  - When the hold ends and the soft flag is set: `sw_ack`=1 for exactly one cycle, coincident with the first cycle `rst_o`=0; soft flag cleared.
- `sw_req` sampled during HOLD is ignored. It neither extends nor restarts the hold.
- `sw_req` held high continuously: a new hold starts at the first RUN posedge. That gives one RUN cycle between holds, and `sw_ack` pulses each time.
- `rst` asserted mid-HOLD or mid-RUN:
  - Immediate async return to reset values.
  - Any pending soft flag is dropped; no `sw_ack`.
  - On re-release the full sequence restarts from E0.
- `rst` pulse shorter than one clock period: still resets the sync chain; full sequence reruns.
- cnt never wraps: HOLD exits at HOLD_CYCLES-1.

Optional Feature:
- Macro: RST_SEQ_MON_EN.
- Defined: built-in checker.
  - Counts posedges with `rst_o`=1 in each hold window.
  - Sets `rst_err` (sticky until `rst`) if a window length ≠ HOLD_CYCLES.
  - Also sets `rst_err` if `rst_o` rises while `rst`=0 without `sw_req` sampled 1 on the prior edge.
- Undefined: checker logic absent; `rst_err` tied 0.

Test Plan:
- Power-on: clk period 10, `rst`=1 until t=25, HOLD_CYCLES=3, SYNC_STAGES=2 -> E0 at t=45; `rst_o` sampled 1 at t=45,55,65 and 0 at t=75 through 200; `rst_done`=1 from t=75.
- Soft reset: in RUN, `sw_req`=1 for one posedge at t=105 -> `rst_o` sampled 1 at t=115,125,135, 0 at t=145; `sw_ack`=1 only in cycle t=145.
- `sw_req` during HOLD: `sw_req` pulses at t=125 -> hold still ends at t=145; exactly one `sw_ack`.
- Mid-hold reset: `rst` pulse at t=120 during soft hold -> `rst_o`=1 immediately; no `sw_ack`; full 2+3 sequence after release.
- HOLD_CYCLES=1: `rst_o` sampled high at E0 only, low at E0+1.
- With RST_SEQ_MON_EN: all scenarios above leave `rst_err`=0. Forcing cnt via a bench force to shorten a window -> `rst_err`=1 and stays 1 until `rst`.
